hidden_layer_mac_array: RTL and testbench

- Parametrised hidden-layer neuron bank. NUM_NEURONS neurons accumulate weighted sums over one input vector of NUM_INPUTS samples, in parallel.
- One unsigned pixel/feature sample enters per accepted beat and is multiplied by a per-neuron signed weight. Products are summed with saturation.
- The scaled, saturated result vector is presented on a valid/ready output.
- Sits between the feature/pixel streamer and the output layer of the drowsiness classifier.

---
 rtl/hidden_layer_pkg.sv | 48 ++++
 rtl/hidden_layer_neuron_mac.sv | 61 ++++++
 rtl/hidden_layer_mac_array.sv | 117 +++++++++++
 tb/tb_hidden_layer_mac_array.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hidden_layer_pkg.sv
// Shared types, default widths and saturation helpers for the hidden-layer neuron bank.
package hidden_layer_pkg;

  localparam int unsigned DEF_DATA_W      = 10;
  localparam int unsigned DEF_WGT_W       = 10;
  localparam int unsigned DEF_ACC_W       = 24;
  localparam int unsigned DEF_NUM_NEURONS = 4;
  localparam int unsigned DEF_NUM_INPUTS  = 16;
  localparam int unsigned DEF_FRAC_BITS   = 6;

  // Saturation math is done at a fixed wide width, then narrowed by the caller.
  localparam int unsigned WIDE_W = 64;
  typedef logic signed [WIDE_W-1:0] wide_t;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    DRAIN  = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  typedef struct packed {
    logic valid;
    logic last;
  } pipe_ctl_t;

  // Clamp x to the signed range of a w-bit two's complement value.
  function automatic wide_t sat_acc(input wide_t x, input int unsigned w);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = -hi - wide_t'(1);
    if (x > hi) begin
      return hi;
    end else if (x < lo) begin
      return lo;
    end
    return x;
  endfunction

  // Output clamp; with relu set, negative values collapse to zero first.
  function automatic wide_t sat_out(input wide_t x, input int unsigned w, input bit relu);
    if (relu && (x < wide_t'(0))) begin
      return wide_t'(0);
    end
    return sat_acc(x, w);
  endfunction

endpackage

// File: rtl/hidden_layer_neuron_mac.sv
// One neuron: registered product, saturating accumulator and scaled/saturated output register.
// Build option: define HIDDEN_LAYER_RELU_EN to clip negative results to zero at the output load.
module hidden_layer_neuron_mac
  import hidden_layer_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned WGT_W     = DEF_WGT_W,
  parameter int unsigned ACC_W     = DEF_ACC_W,
  parameter int unsigned FRAC_BITS = DEF_FRAC_BITS
) (
  input  logic              Clock,
  input  logic              Clear,
  input  logic              beat,
  input  logic [DATA_W-1:0] in_data,
  input  logic [WGT_W-1:0]  weight,
  input  logic              p_valid,
  input  logic              acc_clear,
  input  logic              out_load,
  output logic [DATA_W-1:0] out_data
);

`ifdef HIDDEN_LAYER_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic signed [ACC_W-1:0]  prod_c;
  logic signed [ACC_W-1:0]  prod_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_next_c;
  logic signed [DATA_W-1:0] scaled_c;

  // Sample is unsigned: a zero MSB keeps it positive in the signed multiply.
  always_comb begin
    prod_c     = ACC_W'($signed({1'b0, in_data})) * ACC_W'($signed(weight));
    acc_next_c = ACC_W'(sat_acc(wide_t'(acc_q) + wide_t'(prod_q), ACC_W));
    scaled_c   = DATA_W'(sat_out(wide_t'(acc_q >>> FRAC_BITS), DATA_W, RELU));
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      prod_q   <= '0;
      acc_q    <= '0;
      out_data <= '0;
    end else begin
      if (beat) begin
        prod_q <= prod_c;
      end
      if (acc_clear) begin
        acc_q <= '0;
      end else if (p_valid) begin
        acc_q <= acc_next_c;
      end
      if (out_load) begin
        out_data <= scaled_c;
      end
    end
  end

endmodule

// File: rtl/hidden_layer_mac_array.sv
// Hidden-layer neuron bank: NUM_NEURONS parallel MACs over a NUM_INPUTS-sample vector,
// with a valid/ready result port. Build option HIDDEN_LAYER_RELU_EN enables output ReLU.
module hidden_layer_mac_array
  import hidden_layer_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned WGT_W       = DEF_WGT_W,
  parameter int unsigned ACC_W       = DEF_ACC_W,
  parameter int unsigned NUM_NEURONS = DEF_NUM_NEURONS,
  parameter int unsigned NUM_INPUTS  = DEF_NUM_INPUTS,
  parameter int unsigned FRAC_BITS   = DEF_FRAC_BITS
) (
  input  logic                          Clock,
  input  logic                          Clear,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_data,
  input  logic [NUM_NEURONS*WGT_W-1:0]  in_weight,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_NEURONS*DATA_W-1:0] out_data,
  output logic                          busy
);

  localparam int unsigned CNT_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   count_q;
  pipe_ctl_t          pipe_q;
  logic               accept_c;
  logic               last_c;
  logic               hs_c;
  logic               load_c;

  always_comb begin
    accept_c = in_valid && in_ready;
    last_c   = (count_q == CNT_W'(NUM_INPUTS - 1));
    hs_c     = out_valid && out_ready;
  end

  // Next-state: DRAIN holds while the last product is still being added.
  always_comb begin
    state_d = state_q;
    load_c  = 1'b0;
    case (state_q)
      ACCUM: begin
        if (accept_c && last_c) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!(pipe_q.valid && pipe_q.last)) begin
          state_d = OUTPUT;
          load_c  = 1'b1;
        end
      end
      OUTPUT: begin
        if (hs_c) begin
          state_d = ACCUM;
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state_q   <= ACCUM;
      count_q   <= '0;
      pipe_q    <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state_q      <= state_d;
      pipe_q.valid <= accept_c;
      pipe_q.last  <= accept_c && last_c;
      in_ready     <= (state_d == ACCUM);
      if (accept_c) begin
        count_q <= last_c ? '0 : count_q + CNT_W'(1);
      end
      if (load_c) begin
        out_valid <= 1'b1;
      end else if (hs_c) begin
        out_valid <= 1'b0;
      end
      if (accept_c) begin
        busy <= 1'b1;
      end else if (hs_c) begin
        busy <= 1'b0;
      end
    end
  end

  for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_neuron
    hidden_layer_neuron_mac #(
      .DATA_W    (DATA_W),
      .WGT_W     (WGT_W),
      .ACC_W     (ACC_W),
      .FRAC_BITS (FRAC_BITS)
    ) u_neuron (
      .Clock     (Clock),
      .Clear     (Clear),
      .beat      (accept_c),
      .in_data   (in_data),
      .weight    (in_weight[n*WGT_W +: WGT_W]),
      .p_valid   (pipe_q.valid),
      .acc_clear (hs_c),
      .out_load  (load_c),
      .out_data  (out_data[n*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_hidden_layer_mac_array.sv
// Bench for hidden_layer_mac_array: default build, an ACC_W=20 twin in lockstep, and a 1x1 instance.
module tb_hidden_layer_mac_array;

  logic        Clock = 1'b0;
  logic        Clear;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [9:0]  in_data;
  logic [39:0] in_weight, out_data;
  logic        in_ready_s, out_valid_s, busy_s;
  logic [39:0] out_data_s;
  logic        in_valid1, in_ready1, out_valid1, busy1;
  logic        out_ready1 = 1'b1;
  logic [9:0]  in_data1, in_weight1, out_data1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_acc_cyc = 0;
  bit prev_ov = 1'b0;
  bit post_hs = 1'b0;

  typedef struct {
    logic [9:0]  d;
    logic [39:0] w;
    logic [39:0] exp;
  } vec_t;
  typedef struct {
    logic [39:0] e24;
    logic [39:0] e20;
  } sb_t;

  vec_t        tbl[5];
  sb_t         sb[$];
  logic [9:0]  vd[16];
  logic [39:0] vw[16];

  hidden_layer_mac_array dut (
    .Clock(Clock), .Clear(Clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_weight(in_weight), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy));

  hidden_layer_mac_array #(.ACC_W(20)) dut_sat (
    .Clock(Clock), .Clear(Clear), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_data(in_data), .in_weight(in_weight), .out_valid(out_valid_s),
    .out_ready(out_ready), .out_data(out_data_s), .busy(busy_s));

  hidden_layer_mac_array #(.NUM_INPUTS(1), .NUM_NEURONS(1)) dut_one (
    .Clock(Clock), .Clear(Clear), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data1), .in_weight(in_weight1), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_data(out_data1), .busy(busy1));

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired or no expectation (cycle %0d)", name, cyc);
  endtask

  function automatic longint sx10(input logic [9:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint relu(input longint v);
`ifdef HIDDEN_LAYER_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [39:0] pk(input int a, input int b, input int c, input int e);
    return {10'(e), 10'(c), 10'(b), 10'(a)};
  endfunction

  function automatic logic [39:0] relu_vec(input logic [39:0] v);
    logic [39:0] r;
    for (int n = 0; n < 4; n++) r[n*10 +: 10] = 10'(relu(sx10(v[n*10 +: 10])));
    return r;
  endfunction

  // Reference: per-beat saturating accumulate, floor shift by 6, clamp to 10-bit signed.
  function automatic logic [39:0] model(input int acc_w);
    longint acc[4];
    longint amax, amin, o;
    logic [39:0] r;
    amax = (longint'(1) << (acc_w - 1)) - 1;
    amin = -amax - 1;
    for (int n = 0; n < 4; n++) acc[n] = 0;
    for (int i = 0; i < 16; i++) begin
      for (int n = 0; n < 4; n++) begin
        acc[n] = acc[n] + longint'(vd[i]) * sx10(vw[i][n*10 +: 10]);
        if (acc[n] > amax) acc[n] = amax;
        if (acc[n] < amin) acc[n] = amin;
      end
    end
    for (int n = 0; n < 4; n++) begin
      o = relu(acc[n] >>> 6);
      if (o > 511) o = 511;
      if (o < -512) o = -512;
      r[n*10 +: 10] = 10'(o);
    end
    return r;
  endfunction

  // Drive nbeats of vd/vw; a full vector pushes its expectation once the last beat is taken.
  task automatic run_vector(input bit gaps, input bit use_tbl, input logic [39:0] tbl_exp,
                            input int nbeats);
    int waited;
    int acc_cyc;
    sb_t e;
    acc_cyc = 0;
    for (int i = 0; i < nbeats; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          in_valid  = 1'b0;
          in_data   = 10'($urandom);
          in_weight = 40'({$urandom, $urandom});
          @(posedge Clock); #1;
        end
      end
      in_valid  = 1'b1;
      in_data   = vd[i];
      in_weight = vw[i];
      waited    = 0;
      forever begin
        @(negedge Clock);
        if (in_ready) break;
        waited++;
        if (waited > 50) break;
      end
      if (!in_ready) begin
        fail_now("beat_accept_timeout");
        in_valid = 1'b0;
        return;
      end
      acc_cyc = cyc;
      @(posedge Clock); #1;
    end
    in_valid = 1'b0;
    if (nbeats == 16) begin
      e.e24 = use_tbl ? tbl_exp : model(24);
      e.e20 = model(20);
      last_acc_cyc = acc_cyc;
      sb.push_back(e);
    end
  endtask

  task automatic wait_empty();
    for (int k = 0; k < 100; k++) begin
      @(negedge Clock);
      if (sb.size() == 0) break;
    end
    if (sb.size() != 0) fail_now("scoreboard_drain");
  endtask

  // Result monitor: latency, payload against scoreboard, busy/in_ready around the handshake.
  always @(negedge Clock) begin
    sb_t e;
    if (!Clear) begin
      prev_ov = 1'b0;
      post_hs = 1'b0;
    end else begin
      if (post_hs) chk("post_hs_busy_ready", longint'({busy, in_ready}), 1);
      post_hs = 1'b0;
      if (out_valid && !prev_ov) chk("latency", longint'(cyc - last_acc_cyc), 3);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          fail_now("unexpected_result");
        end else begin
          e = sb.pop_front();
          for (int n = 0; n < 4; n++) begin
            chk($sformatf("out%0d", n), sx10(out_data[n*10 +: 10]), sx10(e.e24[n*10 +: 10]));
            chk($sformatf("sat_out%0d", n), sx10(out_data_s[n*10 +: 10]), sx10(e.e20[n*10 +: 10]));
          end
        end
        chk("busy_at_hs", longint'(busy), 1);
        chk("sat_lockstep", longint'({in_ready_s, busy_s, out_valid_s}),
            longint'({in_ready, busy, out_valid}));
        post_hs = 1'b1;
      end
      prev_ov = out_valid;
    end
  end

  initial begin
    logic [39:0] snap;
    int n_acc, n_out, prev_acc;
    Clear = 1'b0; in_valid = 1'b0; in_data = '0; in_weight = '0; out_ready = 1'b1;
    in_valid1 = 1'b0; in_data1 = '0; in_weight1 = '0;

    tbl[0] = '{10'd64,   pk(1, 1, 1, 1),          pk(16, 16, 16, 16)};
    tbl[1] = '{10'd1023, pk(511, -512, 3, 0),     pk(511, -512, 511, 0)};
    tbl[2] = '{10'd100,  pk(-1, 2, 40, -7),       pk(-25, 50, 511, -175)};
    tbl[3] = '{10'd0,    pk(-512, 511, 100, -100), pk(0, 0, 0, 0)};
    tbl[4] = '{10'd5,    pk(1, -1, 13, -13),      pk(1, -2, 16, -17)};

    repeat (3) @(posedge Clock);
    @(negedge Clock);
    chk("reset_ctl", longint'({out_valid, busy, in_ready}), 1);
    chk("reset_data", longint'(out_data), 0);
    chk("reset_one_ctl", longint'({out_valid1, busy1, in_ready1}), 1);
    @(posedge Clock); #1 Clear = 1'b1;

    // Constant-sample vectors from the table, out_ready held high.
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < 16; i++) begin
        vd[i] = tbl[t].d;
        vw[i] = tbl[t].w;
      end
      run_vector(1'b0, 1'b1, relu_vec(tbl[t].exp), 16);
    end

    // Random samples and per-beat weights with random in_valid gaps.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 16; i++) begin
        vd[i] = 10'($urandom);
        vw[i] = 40'({$urandom, $urandom});
      end
      run_vector(1'b1, 1'b0, '0, 16);
    end
    wait_empty();

    // Downstream stall: result must hold and input stay closed for 10 cycles.
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      vd[i] = 10'($urandom);
      vw[i] = 40'({$urandom, $urandom});
    end
    run_vector(1'b1, 1'b0, '0, 16);
    for (int k = 0; k < 20; k++) begin
      @(negedge Clock);
      if (out_valid) break;
    end
    if (!out_valid) fail_now("stall_out_valid_wait");
    snap = out_data;
    for (int k = 0; k < 10; k++) begin
      @(negedge Clock);
      chk("stall_hold", longint'({out_valid, in_ready, busy, out_data == snap}), 4'b1011);
    end
    @(posedge Clock); #1 out_ready = 1'b1;
    wait_empty();

    // Clear after beat 7 discards the partial sum.
    for (int i = 0; i < 16; i++) begin
      vd[i] = 10'd64;
      vw[i] = pk(1, 1, 1, 1);
    end
    run_vector(1'b0, 1'b0, '0, 7);
    Clear = 1'b0;
    @(negedge Clock);
    chk("clear_ctl", longint'({out_valid, busy, in_ready}), 1);
    chk("clear_data", longint'(out_data), 0);
    @(posedge Clock); #1 Clear = 1'b1;
    run_vector(1'b0, 1'b1, relu_vec(pk(16, 16, 16, 16)), 16);
    wait_empty();

    // Single-input, single-neuron instance: one vector every 4 cycles.
    in_data1 = 10'd200;
    in_weight1 = 10'(-7);
    @(posedge Clock); #1 in_valid1 = 1'b1;
    n_acc = 0; n_out = 0; prev_acc = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge Clock);
      if (in_valid1 && in_ready1) begin
        if (n_acc > 0) chk("one_spacing", longint'(cyc - prev_acc), 4);
        prev_acc = cyc;
        n_acc++;
      end
      if (out_valid1) begin
        chk("one_data", sx10(out_data1), relu(-22));
        n_out++;
      end
    end
    @(posedge Clock); #1 in_valid1 = 1'b0;
    chk("one_accepts", longint'(n_acc), 10);
    chk("one_results", longint'(n_out), 10);

    repeat (5) @(posedge Clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
